// File: rtl/sprite_pixel_pipe_if.sv
// Signal bundle between the sprite pixel pipe, the raster/player logic and the sprite ROM.
// The master modport is the pipe itself; the slave modport is its surrounding environment.
interface sprite_pixel_pipe_if;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        video_on;
    logic        frame_tick;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        facing_left;
    logic        walking;
    logic [13:0] rom_addr;
    logic        rom_reverse;
    logic [1:0]  frame_sel;
    logic [11:0] rom_data;
    logic [11:0] pixel_out;
    logic        pixel_opaque;

    modport master (
        input  hcount, vcount, video_on, frame_tick,
        input  pos_x, pos_y, facing_left, walking,
        input  rom_data,
        output rom_addr, rom_reverse, frame_sel,
        output pixel_out, pixel_opaque
    );

    modport slave (
        output hcount, vcount, video_on, frame_tick,
        output pos_x, pos_y, facing_left, walking,
        output rom_data,
        input  rom_addr, rom_reverse, frame_sel,
        input  pixel_out, pixel_opaque
    );
endinterface

// File: rtl/sprite_pixel_pipe.sv
// Sprite ROM front end: raster-to-ROM address, transparency keying and the
// idle/walk animation sequencer. Pixel latency from hcount/vcount is 3 clocks.
module sprite_pixel_pipe #(
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter logic [11:0] KEY_COLOR       = 12'h0F0
) (
    input  logic                clk,
    input  logic                rst_n,
    sprite_pixel_pipe_if.master bus
);
    // state | meaning
    // IDLE  | standing pose, frame_sel 00
    // WALK1 | first walk pose, frame_sel 01
    // WALK2 | second walk pose, frame_sel 10
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WALK1 = 2'b01,
        WALK2 = 2'b10
    } anim_state_t;

    localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);

    logic [9:0]  lat_x;
    logic [9:0]  lat_y;
    logic        lat_rev;

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_box;
    logic [6:0]  col;
    logic [6:0]  row;

    logic [13:0] rom_addr_q;
    logic        in_box_d1;
    logic        in_box_d2;
    logic [11:0] pixel_q;
    logic        opaque_q;

    anim_state_t state_q;
    anim_state_t state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [1:0]  frame_sel_q;
    logic [1:0]  frame_sel_d;

    // Position and mirror only move during vertical blank, so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_x   <= '0;
            lat_y   <= '0;
            lat_rev <= 1'b0;
        end else if (bus.frame_tick) begin
            lat_x   <= bus.pos_x;
            lat_y   <= bus.pos_y;
            lat_rev <= bus.facing_left;
        end
    end

    // 11-bit box ends keep a sprite hanging off the right/bottom edge clipped.
    assign x_end  = {1'b0, lat_x} + 11'd128;
    assign y_end  = {1'b0, lat_y} + 11'd128;
    assign in_box = bus.video_on
                 && (bus.hcount >= lat_x) && ({1'b0, bus.hcount} < x_end)
                 && (bus.vcount >= lat_y) && ({1'b0, bus.vcount} < y_end);
    assign col    = bus.hcount[6:0] - lat_x[6:0];
    assign row    = bus.vcount[6:0] - lat_y[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            in_box_d1  <= 1'b0;
            in_box_d2  <= 1'b0;
            pixel_q    <= '0;
            opaque_q   <= 1'b0;
        end else begin
            rom_addr_q <= in_box ? {row, col} : 14'd0;
            in_box_d1  <= in_box;
            in_box_d2  <= in_box_d1;
            if (in_box_d2 && (bus.rom_data != KEY_COLOR)) begin
                pixel_q  <= bus.rom_data;
                opaque_q <= 1'b1;
            end else begin
                pixel_q  <= 12'h000;
                opaque_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_sel_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_sel_q <= frame_sel_d;
        end
    end

    // Step timer counts down to zero; dropping walking always beats a pose change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (bus.walking) begin
                        state_d = WALK1;
                        cnt_d   = STEP_LAST;
                    end
                end
                WALK1, WALK2: begin
                    if (!bus.walking) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == 8'd0) begin
                        state_d = (state_q == WALK1) ? WALK2 : WALK1;
                        cnt_d   = STEP_LAST;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        frame_sel_d = 2'b00;
        case (state_d)
            WALK1:   frame_sel_d = 2'b01;
            WALK2:   frame_sel_d = 2'b10;
            default: frame_sel_d = 2'b00;
        endcase
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.rom_reverse  = lat_rev;
    assign bus.frame_sel    = frame_sel_q;
    assign bus.pixel_out    = pixel_q;
    assign bus.pixel_opaque = opaque_q;
endmodule

// File: doc/sprite_pixel_pipe.md
# sprite_pixel_pipe

- Sits directly upstream of the 128x128 sprite ROM. Converts the VGA raster position and a latched player position into the ROM's 14-bit pixel address, mirror flag and animation-frame select.
- Delays the in-sprite flag to line up with the ROM's one-cycle read latency, then applies transparency keying.
- Produces a registered, pipeline-aligned pixel and an opaque flag for the background/foreground mux.
- Owns the idle/walk animation state machine, advanced once per video frame.

## Interface
Parameters:
- FRAMES_PER_STEP, 8: video frames each walk frame is held; legal range 1..255.
- KEY_COLOR, 12'h0F0: RGB444 value treated as transparent.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- hcount  in  10  raster column, 0..799
- vcount  in  10  raster row, 0..524
- video_on  in  1  visible-area flag for hcount/vcount
- frame_tick  in  1  one-cycle pulse per frame, asserted during vertical blank
- pos_x  in  10  requested sprite left edge
- pos_y  in  10  requested sprite top edge
- facing_left  in  1  requested mirror direction
- walking  in  1  requested walk animation
- rom_addr  out  14  ROM address, {row[6:0], col[6:0]}
- rom_reverse  out  1  ROM mirror flag
- frame_sel  out  2  animation ROM select: 00 idle, 01 walk1, 10 walk2; 11 never driven
- rom_data  in  12  ROM pixel output, valid one cycle after rom_addr
- pixel_out  out  12  keyed sprite pixel
- pixel_opaque  out  1  pixel_out is a sprite pixel

## Operation
- **Frame-boundary latch:** on a cycle with frame_tick=1, register pos_x, pos_y and facing_left into lat_x, lat_y, lat_rev. rom_reverse = lat_rev. No mid-frame tearing.
- **Address stage (registered):**
  - dx = hcount - lat_x and dy = vcount - lat_y, both in 11-bit arithmetic.
  - in_box = video_on && hcount >= lat_x && hcount < lat_x+128 && vcount >= lat_y && vcount < lat_y+128. Sums are 11 bits, so a box crossing the screen edge clips rather than wraps.
  - rom_addr <= {dy[6:0], dx[6:0]} when in_box, else 14'd0.
  - in_box_d1 <= in_box.
- **Align stage:** in_box_d2 <= in_box_d1, matching the ROM's registered read.
- **Key stage (registered):**
  - If in_box_d2 && rom_data != KEY_COLOR: pixel_out <= rom_data, pixel_opaque <= 1.
  - Otherwise: pixel_out <= 12'h000, pixel_opaque <= 0.
- **Animation FSM** (states IDLE, WALK1, WALK2; 8-bit step counter). State and counter change only on frame_tick cycles.
  - IDLE: walking=1 -> WALK1, counter <= 0. Otherwise stay.
  - WALK1/WALK2:
    - walking=0 -> IDLE, counter <= 0.
    - Else if counter == FRAMES_PER_STEP-1 -> toggle to the other WALK state, counter <= 0.
    - Else counter += 1.
  - frame_sel is a registered decode of the state.

## Timing
- **Reset values:** all outputs and internal registers 0 (lat_x/lat_y = 0, lat_rev = 0), state IDLE, frame_sel = 00.
- **Latency:** hcount/vcount sampled at edge n -> rom_addr valid after edge n+1 -> rom_data valid after edge n+2 -> pixel_out/pixel_opaque valid after edge n+3. Fixed latency 3; the display timing generator delays hsync/vsync by 3 to match.
- **Position/direction change:** a change on frame_tick at edge t reaches rom_addr/rom_reverse after edge t+1. Because frame_tick falls in vertical blank, the whole next frame uses the new values.
- **walking toggles:** walking changing between frame_ticks has no effect until the next frame_tick. With FRAMES_PER_STEP=1, WALK states alternate every frame_tick.
- **Simultaneous events:** walking=0 on the same frame_tick as a counter wrap -> IDLE wins.
- **rst_n mid-frame:** outputs clear immediately (asynchronously). Pipeline refills 3 cycles after rst_n is released. The sprite stays at 0,0 until the first frame_tick.
- **Out-of-box pixels:** rom_addr 0, pixel_opaque 0, regardless of what rom_data returns.

## Test plan
- **Reset:** rst_n=0 mid-line.
  - Required: all outputs 0 and frame_sel=00 immediately, with no clock edge.
  - After release, pixel_opaque stays 0 until in_box data has propagated.
- **Address and latency:** frame_tick with pos=(100,50), then raster at hcount=105, vcount=53.
  - Required: rom_addr=14'd389 (3*128+5) one cycle later.
  - With a model ROM returning 12'hABC, pixel_out=12'hABC and pixel_opaque=1 exactly 3 cycles after the sample.
- **Edges and clipping:** pos_x=600.
  - Required: pixel_opaque=1 for hcount 600..639 only.
  - hcount=99 with pos_x=100 gives opaque=0.
  - hcount=227 (pos_x=100) gives col 127; hcount=228 gives opaque=0.
- **Transparency:** ROM returns 12'h0F0 inside the box -> pixel_out=0, opaque=0. ROM returns 12'h0F1 -> passed through, opaque=1.
- **Mirror latch:** facing_left=1 asserted mid-frame -> rom_reverse stays 0 until the cycle after the next frame_tick, then reads 1.
- **Animation:** FRAMES_PER_STEP=3, walking=1.
  - Required frame_sel after successive frame_ticks: 01,01,01,10,10,10,01,...
  - walking=0 coinciding with a wrap tick -> 00.
